// File: rtl/udp_panel_pkg.sv
// Shared definitions for the UDP panel reader/writer blocks: default source-port MSB,
// controller state encoding and pixel field widths.
package udp_panel_pkg;

    localparam logic [7:0]  PORT_MSB_DEFAULT = 8'h66;
    localparam int unsigned ADDR_W           = 14;
    localparam int unsigned CHAN_W           = 6;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWaitData,
        StSend
    } panel_state_e;

    // Packs a pixel as {address, R, G, B}, keeping the low CHAN_W bits of each 8-bit channel.
    function automatic logic [31:0] pack_pixel(input logic [ADDR_W-1:0] addr,
                                               input logic [23:0]       rdat);
        return {addr, rdat[16 +: CHAN_W], rdat[8 +: CHAN_W], rdat[0 +: CHAN_W]};
    endfunction

endpackage

// File: rtl/udp_byte_serializer.sv
// Loads a 32-bit word and emits it MSB byte first over four ready/valid beats.
// The last flag accompanies only the fourth byte of a word loaded with load_last set.
module udp_byte_serializer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_word,
    input  logic        load_last,
    output logic        valid,
    output logic [7:0]  data,
    output logic        last,
    input  logic        ready,
    output logic        done
);

    logic [31:0] word_q, word_d;
    logic [1:0]  idx_q, idx_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;

    // Next state: load a fresh word, or advance one byte per accepted beat.
    always_comb begin
        word_d  = word_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (load) begin
            word_d  = load_word;
            idx_d   = 2'd0;
            valid_d = 1'b1;
            last_d  = load_last;
        end else if (valid_q && ready) begin
            if (idx_q == 2'd3) begin
                valid_d = 1'b0;
            end else begin
                idx_d = idx_q + 2'd1;
            end
        end
    end

    // State registers; reset drops valid at once, abandoning any word in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q  <= 32'h0;
            idx_q   <= 2'd0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            word_q  <= word_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    // Byte select, MSB first.
    always_comb begin
        data = 8'h00;
        unique case (idx_q)
            2'd0: data = word_q[31:24];
            2'd1: data = word_q[23:16];
            2'd2: data = word_q[15:8];
            2'd3: data = word_q[7:0];
            default: data = 8'h00;
        endcase
    end

    assign valid = valid_q;
    assign last  = valid_q && last_q && (idx_q == 2'd3);
    assign done  = valid_q && ready && (idx_q == 2'd3);

endmodule

// File: rtl/udp_panel_reader.sv
// Panel readback engine: accepts a request, reads N pixels from the selected panels one at a
// time, and streams them as a UDP packet, 4 bytes per pixel.
// Optional build macro UDP_PANEL_READER_HDR_EN prefixes a 4-byte request header.
module udp_panel_reader
    import udp_panel_pkg::*;
#(
    parameter logic [7:0] PORT_MSB = PORT_MSB_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_ip,
    input  logic [15:0] req_port,
    input  logic [5:0]  req_en,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_count,
    output logic [5:0]  ctrl_ren,
    output logic [15:0] ctrl_raddr,
    input  logic [23:0] ctrl_rdat,
    output logic        udp_sink_valid,
    output logic        udp_sink_last,
    input  logic        udp_sink_ready,
    output logic [15:0] udp_sink_src_port,
    output logic [15:0] udp_sink_dst_port,
    output logic [31:0] udp_sink_ip_address,
    output logic [15:0] udp_sink_length,
    output logic [31:0] udp_sink_data
);

    panel_state_e      state_q, state_d;
    logic              init_q;
    logic [5:0]        en_q, en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [8:0]        remain_q, remain_d;
    logic [15:0]       src_q, src_d;
    logic [15:0]       dst_q, dst_d;
    logic [31:0]       ip_q, ip_d;
    logic [15:0]       len_q, len_d;
`ifdef UDP_PANEL_READER_HDR_EN
    logic              hdr_q, hdr_d;
`endif

    logic        accept;
    logic [8:0]  n_req;
    logic        ser_load;
    logic [31:0] ser_word;
    logic        ser_last;
    logic        ser_valid;
    logic [7:0]  ser_data;
    logic        ser_done;
    logic        ser_last_out;

    assign req_ready = init_q && (state_q == StIdle);
    assign accept    = req_valid && req_ready;
    assign n_req     = (req_count == 8'd0) ? 9'd256 : {1'b0, req_count};

    // Next-state, request latching and serializer load control.
    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        src_d    = src_q;
        dst_d    = dst_q;
        ip_d     = ip_q;
        len_d    = len_q;
`ifdef UDP_PANEL_READER_HDR_EN
        hdr_d    = hdr_q;
`endif
        ser_load = 1'b0;
        ser_word = pack_pixel(addr_q, ctrl_rdat);
        ser_last = (remain_q == 9'd1);
        case (state_q)
            StIdle: begin
                if (accept) begin
                    en_d     = req_en;
                    addr_d   = req_addr[ADDR_W-1:0];
                    remain_d = n_req;
                    src_d    = {PORT_MSB, 2'b00, req_en};
                    dst_d    = req_port;
                    ip_d     = req_ip;
`ifdef UDP_PANEL_READER_HDR_EN
                    len_d    = {5'b0, n_req, 2'b00} + 16'd4;
`else
                    len_d    = {5'b0, n_req, 2'b00};
`endif
                    // A request with no panel selected is consumed without a reply.
                    if (req_en != 6'd0) begin
`ifdef UDP_PANEL_READER_HDR_EN
                        state_d  = StSend;
                        ser_load = 1'b1;
                        ser_word = {req_addr, req_count, 2'b00, req_en};
                        ser_last = 1'b0;
                        hdr_d    = 1'b1;
`else
                        state_d  = StRead;
`endif
                    end
                end
            end
            StRead: begin
                state_d = StWaitData;
            end
            StWaitData: begin
                // Read data arrives exactly one cycle after the strobe.
                ser_load = 1'b1;
                state_d  = StSend;
            end
            StSend: begin
                if (ser_done) begin
`ifdef UDP_PANEL_READER_HDR_EN
                    if (hdr_q) begin
                        hdr_d   = 1'b0;
                        state_d = StRead;
                    end else begin
`else
                    begin
`endif
                        remain_d = remain_q - 9'd1;
                        addr_d   = addr_q + 1'b1;
                        state_d  = (remain_q == 9'd1) ? StIdle : StRead;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Controller registers; init_q holds req_ready low for the reset cycle itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            init_q   <= 1'b0;
            en_q     <= 6'd0;
            addr_q   <= '0;
            remain_q <= 9'd0;
            src_q    <= 16'h0;
            dst_q    <= 16'h0;
            ip_q     <= 32'h0;
            len_q    <= 16'h0;
`ifdef UDP_PANEL_READER_HDR_EN
            hdr_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            init_q   <= 1'b1;
            en_q     <= en_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            ip_q     <= ip_d;
            len_q    <= len_d;
`ifdef UDP_PANEL_READER_HDR_EN
            hdr_q    <= hdr_d;
`endif
        end
    end

    udp_byte_serializer u_ser (
        .clk       (clk),
        .reset     (reset),
        .load      (ser_load),
        .load_word (ser_word),
        .load_last (ser_last),
        .valid     (ser_valid),
        .data      (ser_data),
        .last      (ser_last_out),
        .ready     (udp_sink_ready),
        .done      (ser_done)
    );

    // Panel read strobe for the single READ cycle of each pixel.
    always_comb begin
        ctrl_ren   = 6'd0;
        ctrl_raddr = 16'h0;
        if (state_q == StRead) begin
            ctrl_ren   = en_q;
            ctrl_raddr = {2'b00, addr_q};
        end
    end

    assign udp_sink_valid      = ser_valid;
    assign udp_sink_last       = ser_last_out;
    assign udp_sink_data       = {24'h0, ser_data};
    assign udp_sink_src_port   = src_q;
    assign udp_sink_dst_port   = dst_q;
    assign udp_sink_ip_address = ip_q;
    assign udp_sink_length     = len_q;

    // Channel MSBs and the top address bits are deliberately dropped.
    logic unused_bits;
    assign unused_bits = ^{ctrl_rdat[23:22], ctrl_rdat[15:14], ctrl_rdat[7:6], req_addr[15:14]};

endmodule

// File: doc/udp_panel_reader.md
UDP_PANEL_READER -- requirements
Module: udp_panel_reader

Interface
REQ-001 SHALL have parameter PORT_MSB, default 8'h66; upper byte of UDP source port on emitted packets.
REQ-002 SHALL have port clk  input  1  single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req_valid input 1 and req_ready output 1; readback request handshake.
REQ-005 SHALL have ports req_ip input 32 and req_port input 16; destination IP address and UDP port of the reply.
REQ-006 SHALL have ports req_en input 6, req_addr input 16 and req_count input 8; panel select, first pixel address, and pixel count (0 means 256).
REQ-007 SHALL have ports ctrl_ren output 6, ctrl_raddr output 16 and ctrl_rdat input 24; panel read port with fixed 1-cycle read latency.
REQ-008 SHALL have ports udp_sink_valid output 1, udp_sink_last output 1 and udp_sink_ready input 1; reply stream handshake.
REQ-009 SHALL have ports udp_sink_src_port output 16, udp_sink_dst_port output 16, udp_sink_ip_address output 32, udp_sink_length output 16 and udp_sink_data output 32; one byte per beat, carried in data[7:0], with data[31:8]=0.

Function
REQ-010 SHALL implement states IDLE, READ, WAIT_DATA, SEND; IDLE->READ on req_valid&&req_ready; READ->WAIT_DATA after one cycle; WAIT_DATA->SEND after one cycle; SEND->READ after byte 3 is accepted and pixels remain; SEND->IDLE after the final byte is accepted.
REQ-011 SHALL assert req_ready only in IDLE and SHALL latch all req_* fields on acceptance.
REQ-012 SHALL drive ctrl_ren=latched req_en for exactly one cycle in READ, with ctrl_raddr={2'b00, addr[13:0]}, and SHALL drive ctrl_ren=0 otherwise.
REQ-013 SHALL capture ctrl_rdat in WAIT_DATA and pack it as word={addr[13:0], rdat[21:16], rdat[13:8], rdat[5:0]}.
REQ-014 SHALL emit the word MSB byte first, one byte per udp_sink_valid&&udp_sink_ready beat.
REQ-015 SHALL hold valid, data, last and all header fields stable while valid is high and ready is low.
REQ-016 SHALL assert udp_sink_last only on the final byte of the final pixel.
REQ-017 SHALL drive udp_sink_length = 4*N bytes, where N is the pixel count (0 means 256).
REQ-018 SHALL drive src_port={PORT_MSB,2'b00,req_en}, dst_port=req_port and ip_address=req_ip for the whole packet.
REQ-019 SHALL increment the pixel address after each pixel and wrap 14'h3FFF to 14'h0000.
REQ-020 SHALL ignore req_valid while busy; no queuing.
REQ-021 SHALL not emit a packet when req_en==0; the request is accepted and dropped, and the block returns to IDLE next cycle.

Reset
REQ-022 SHALL on reset drive state=IDLE, req_ready=0, ctrl_ren=0, ctrl_raddr=0, udp_sink_valid=0, udp_sink_last=0, and all other udp_sink_* outputs =0.
REQ-023 SHALL raise req_ready the first cycle after reset deasserts.
REQ-024 SHALL abort a packet in flight when reset is asserted, with no last beat emitted.

Configuration
REQ-025 SHALL, with UDP_PANEL_READER_HDR_EN defined, prefix 4 header bytes {req_addr[15:8], req_addr[7:0], req_count, {2'b00,req_en}} and set length=4*N+4.
REQ-026 SHALL, without UDP_PANEL_READER_HDR_EN, emit pixel bytes only.

Structure
REQ-027 SHALL place PORT_MSB default, the state encoding, and the pixel field widths (ADDR_W=14, CHAN_W=6) in shared package udp_panel_pkg, also used by udp_panel_writer.
REQ-028 SHALL place byte serialization in sub-module udp_byte_serializer (32-bit load, 4 beats, ready/valid, last flag).

Verification
REQ-029 Bench SHALL cover: req en=6'h01, addr=0x0010, count=1, rdat=0x3F2A15, ready=1 -> bytes 0x00,0x43,0xFA,0x95; last on byte 4; length=4; src_port=0x6601.
REQ-030 Bench SHALL cover: count=0 -> 1024 bytes, length=1024, last only on byte 1024.
REQ-031 Bench SHALL cover: addr=0x3FFF, count=2 -> ctrl_raddr 0x3FFF then 0x0000.
REQ-032 Bench SHALL cover: random ready stalls -> byte sequence identical to the no-stall run; outputs stable during each stall.
REQ-033 Bench SHALL cover: reset asserted mid-packet -> valid drops immediately; next request yields a complete packet.
REQ-034 Bench SHALL cover: HDR_EN build, addr=0x0102, count=3, en=5 -> first bytes 0x01,0x02,0x03,0x05; length=16.
